// File: rtl/fetch_align_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_align_buffer
//  Description : Instruction-fetch front end feeding the compressed-instruction
//                expander. Fetches aligned 32-bit words, queues them as
//                16-bit halfwords and presents one instruction per handshake,
//                always realigned to bit 0 (compressed: {16'h0, hw}; 32-bit:
//                {hw_hi, hw_lo}, including word-straddling cases).
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                imem_req/imem_addr  - word-aligned fetch request
//                imem_rvalid/rdata   - response, one cycle after the request
//                redirect_valid/pc   - flush and restart at a halfword PC
//                inst_valid/ready    - instruction handshake
//                inst_word/pc/is_comp- realigned instruction, its PC, width
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_align_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH_HW = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [31:0] inst_pc,
    output logic        inst_is_comp
);

    localparam int PW = $clog2(DEPTH_HW);
    localparam int CW = PW + 1;

    // Halfword storage and its bookkeeping
    logic [15:0]   r_q [DEPTH_HW];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic [31:0]   r_fetch_addr;
    logic [31:0]   r_head_pc;
    logic          r_skip_low;
    logic          r_inflight;
    logic          r_drop;

    logic [CW-1:0] w_free;
    logic [CW-1:0] w_need;
    logic [PW-1:0] w_rd_ptr1;
    logic [PW-1:0] w_wr_ptr1;
    logic [15:0]   w_head;
    logic [15:0]   w_head_hi;
    logic          w_comp;
    logic          w_pop;
    logic          w_push_lo;
    logic          w_push_hi;
    logic [CW-1:0] w_push_n;
    logic [CW-1:0] w_pop_n;

    // A request is only issued when the queue can absorb both its own word
    // and the word of any request still in flight.
    assign w_free    = CW'(DEPTH_HW) - r_count;
    assign w_need    = r_inflight ? CW'(4) : CW'(2);
    assign imem_req  = !rst && !redirect_valid && (w_free >= w_need);
    assign imem_addr = r_fetch_addr;

    assign w_rd_ptr1 = r_rd_ptr + PW'(1);
    assign w_wr_ptr1 = r_wr_ptr + PW'(1);
    assign w_head    = r_q[r_rd_ptr];
    assign w_head_hi = r_q[w_rd_ptr1];
    assign w_comp    = (w_head[1:0] != 2'b11);

    // A 32-bit instruction waits until its upper halfword has been queued.
    assign inst_valid   = !rst && (w_comp ? (r_count != '0) : (r_count >= CW'(2)));
    assign inst_is_comp = w_comp;
    assign inst_word    = w_comp ? {16'h0000, w_head} : {w_head_hi, w_head};
    assign inst_pc      = r_head_pc;

    assign w_pop     = inst_valid && inst_ready && !redirect_valid;
    assign w_pop_n   = w_pop ? (w_comp ? CW'(1) : CW'(2)) : '0;

    // The low halfword is skipped when the fetch started at an odd halfword.
    assign w_push_hi = imem_rvalid && !r_drop;
    assign w_push_lo = imem_rvalid && !r_drop && !r_skip_low;
    assign w_push_n  = CW'(w_push_lo) + CW'(w_push_hi);

    // Queue data needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid) begin
            if (w_push_lo) begin
                r_q[r_wr_ptr]  <= imem_rdata[15:0];
                r_q[w_wr_ptr1] <= imem_rdata[31:16];
            end else if (w_push_hi) begin
                r_q[r_wr_ptr]  <= imem_rdata[31:16];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_inflight   <= 1'b0;
            r_drop       <= 1'b0;
            r_fetch_addr <= {RESET_PC[31:2], 2'b00};
            r_skip_low   <= RESET_PC[1];
            r_head_pc    <= RESET_PC;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_fetch_addr <= r_fetch_addr + 32'd4;
            end

            if (redirect_valid) begin
                r_rd_ptr     <= '0;
                r_wr_ptr     <= '0;
                r_count      <= '0;
                r_fetch_addr <= {redirect_pc[31:2], 2'b00};
                r_skip_low   <= redirect_pc[1];
                r_head_pc    <= redirect_pc;
                // A response to last cycle's request lands in this very cycle
                // and is already discarded by the flush; only a request whose
                // response is still outstanding needs to be dropped later.
                r_drop       <= r_inflight && !imem_rvalid;
            end else begin
                if (imem_rvalid) begin
                    if (r_drop) begin
                        r_drop <= 1'b0;
                    end else if (r_skip_low) begin
                        r_skip_low <= 1'b0;
                    end
                end
                r_wr_ptr <= r_wr_ptr + w_push_n[PW-1:0];
                r_rd_ptr <= r_rd_ptr + w_pop_n[PW-1:0];
                r_count  <= r_count + w_push_n - w_pop_n;
                if (w_pop) begin
                    r_head_pc <= r_head_pc + (w_comp ? 32'd2 : 32'd4);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_align_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_align_buffer
//  Description : Self-checking bench for fetch_align_buffer. A memory model
//                answers fetches; expected instructions are derived by walking
//                PCs over memory and queued; a monitor compares handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_align_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic [31:0] inst_pc;
    logic        inst_is_comp;

    always #5 clk = ~clk;

    fetch_align_buffer #(
        .RESET_PC (32'h0000_0000),
        .DEPTH_HW (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_word      (inst_word),
        .inst_pc        (inst_pc),
        .inst_is_comp   (inst_is_comp)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem_dir [logic [31:0]];
    bit          all32 = 1'b0;

    function automatic logic [31:0] memrd(input logic [31:0] a);
        logic [31:0] wa;
        logic [31:0] x;
        wa = {a[31:2], 2'b00};
        if (mem_dir.exists(wa)) return mem_dir[wa];
        x = wa * 32'h9E37_79B1 + 32'h0123_4567;
        x = x ^ (x >> 15);
        x = x * 32'h85EB_CA6B;
        x = x ^ (x >> 13);
        if (all32) x = x | 32'h0003_0003;
        return x;
    endfunction

    function automatic logic [15:0] hwrd(input logic [31:0] pc);
        logic [31:0] w;
        w = memrd(pc);
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    // Response arrives exactly one cycle after the request.
    initial begin
        logic        v;
        logic [31:0] a;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            v = imem_req;
            a = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = v;
            imem_rdata  = v ? memrd(a) : $urandom;
        end
    end

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
        logic        comp;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] exp_addr = 32'h0;

    // Walk the program from a start PC: the instruction stream is fully
    // determined by memory contents and the halfword length rule.
    task automatic build_exp(input logic [31:0] start);
        logic [31:0] pc;
        logic [15:0] hw;
        exp_t        e;
        sb.delete();
        pc = start;
        repeat (64) begin
            hw   = hwrd(pc);
            e.pc = pc;
            if (hw[1:0] != 2'b11) begin
                e.word = {16'h0000, hw};
                e.comp = 1'b1;
                pc     = pc + 32'd2;
            end else begin
                e.word = {hwrd(pc + 32'd2), hw};
                e.comp = 1'b0;
                pc     = pc + 32'd4;
            end
            sb.push_back(e);
        end
    endtask

    // Monitor: checks reset behaviour, fetch address sequence and handshakes.
    exp_t me;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check_eq("rst_imem_req", 32'(imem_req), 32'd0);
                check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
            end else begin
                if (redirect_valid) check_eq("redirect_imem_req", 32'(imem_req), 32'd0);
                if (imem_req) begin
                    check_eq("imem_addr", imem_addr, exp_addr);
                    exp_addr = exp_addr + 32'd4;
                end
                if (inst_valid && inst_ready && !redirect_valid) begin
                    n_hs++;
                    if (sb.size() == 0) begin
                        check_eq("scoreboard_empty", 32'd1, 32'd0);
                    end else begin
                        me = sb.pop_front();
                        check_eq("inst_pc", inst_pc, me.pc);
                        check_eq("inst_word", inst_word, me.word);
                        check_eq("inst_is_comp", 32'(inst_is_comp), 32'(me.comp));
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit mode);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        all32          = mode;
        build_exp(32'h0);
        exp_addr       = 32'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc, input bit mode);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        all32          = mode;
        exp_addr       = {pc[31:2], 2'b00};
        build_exp(pc);
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        bit          found;
        int          nreq;
        int          hs0;
        logic [31:0] rpc;
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) tick();

        // Basic compressed pair, reset latency, address sequence
        mem_dir[32'h0] = 32'h4505_0001;
        inst_ready = 1'b1;
        do_reset(1'b0);
        #1;
        check_eq("c0_req", 32'(imem_req), 32'd1);
        check_eq("c0_addr", imem_addr, 32'h0);
        tick();
        check_eq("c1_addr", imem_addr, 32'h4);
        check_eq("c1_valid", 32'(inst_valid), 32'd0);
        tick();
        check_eq("c2_valid", 32'(inst_valid), 32'd1);
        check_eq("c2_word", inst_word, 32'h0000_0001);
        repeat (8) tick();

        // Mid-operation reset, then straddling 32-bit instruction
        mem_dir[32'h0] = 32'h0293_4501;
        mem_dir[32'h4] = 32'h4505_0000;
        do_reset(1'b0);

        // Redirect colliding with a handshake at pc 0x8
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (inst_valid && inst_pc == 32'h8) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_eq("reach_pc8", 32'(found), 32'd1);
        do_redirect(32'h300, 1'b0);
        #1;
        check_eq("r1_req", 32'(imem_req), 32'd1);
        check_eq("r1_addr", imem_addr, 32'h300);
        check_eq("r1_valid", 32'(inst_valid), 32'd0);
        tick();
        check_eq("r2_valid", 32'(inst_valid), 32'd0);
        tick();
        check_eq("r3_valid", 32'(inst_valid), 32'd1);
        check_eq("r3_pc", inst_pc, 32'h300);
        repeat (6) tick();

        // Redirect to odd halfword: low halfword must be skipped
        mem_dir[32'h100] = 32'h8082_0001;
        do_redirect(32'h102, 1'b0);
        #1;
        check_eq("odd_addr", imem_addr, 32'h100);
        tick();
        check_eq("odd_r2_valid", 32'(inst_valid), 32'd0);
        tick();
        check_eq("odd_valid", 32'(inst_valid), 32'd1);
        check_eq("odd_pc", inst_pc, 32'h102);
        check_eq("odd_word", inst_word, 32'h0000_8082);
        check_eq("odd_comp", 32'(inst_is_comp), 32'd1);
        repeat (10) tick();

        // Back-pressure with all-32-bit code
        inst_ready = 1'b0;
        do_redirect(32'h200, 1'b1);
        #1;
        nreq = 0;
        for (int i = 0; i < 12; i++) begin
            if (imem_req) nreq++;
            tick();
        end
        check_eq("stall_reqs", 32'(nreq), 32'd4);
        check_eq("stall_req_off", 32'(imem_req), 32'd0);
        check_eq("stall_valid", 32'(inst_valid), 32'd1);
        check_eq("stall_pc", inst_pc, 32'h200);
        inst_ready = 1'b1;
        hs0 = n_hs;
        repeat (30) tick();
        check_eq("throughput_ge25", 32'(n_hs - hs0 >= 25), 32'd1);

        // Redirect one cycle after a request: the stale word must not appear
        do_redirect(32'h10, 1'b0);
        #1;
        check_eq("pre_req_addr", imem_addr, 32'h10);
        tick();
        do_redirect(32'h40, 1'b0);
        tick();
        tick();
        check_eq("drop_valid", 32'(inst_valid), 32'd1);
        check_eq("drop_pc", inst_pc, 32'h40);
        repeat (8) tick();

        // Randomised redirects, back-pressure, one reset and an address wrap
        for (int seg = 0; seg < 25; seg++) begin
            inst_ready = ($urandom % 4) != 0;
            if (seg == 12) begin
                do_reset(1'b0);
            end else begin
                rpc = (seg == 5) ? 32'hFFFF_FFFA : ($urandom & 32'h0000_0FFE);
                do_redirect(rpc, ($urandom % 4) == 0);
            end
            repeat ($urandom_range(8, 50)) begin
                inst_ready = ($urandom % 4) != 0;
                tick();
            end
        end

        inst_ready = 1'b0;
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
